axis_inject_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one NoC mesh injection port among NUM_REQ AXI-Stream sources, e.g. a host passthrough plus several rtl_mvm tiles whose tx streams merge onto a single router input. A grant is held from the first beat of a packet through the beat carrying tlast, so packets are never interleaved. Output goes through a 2-entry skid buffer, so no combinational path exists from m_tready to any s_tready.

---
 rtl/axis_inject_arbiter.sv | 116 +++++++++++
 tb/tb_axis_inject_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_inject_arbiter.sv
// rtl/axis_inject_arbiter.sv - packet-level round-robin arbiter onto one AXI-Stream injection port
// Grant is held for a whole packet; output passes through a 2-entry skid buffer.
module axis_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATAW   = 512,
  parameter int USERW   = 8,
  parameter int DESTW   = 4,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         s_tvalid,
  output logic [NUM_REQ-1:0]         s_tready,
  input  logic [NUM_REQ*DATAW-1:0]   s_tdata,
  input  logic [NUM_REQ*USERW-1:0]   s_tuser,
  input  logic [NUM_REQ*DESTW-1:0]   s_tdest,
  input  logic [NUM_REQ-1:0]         s_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATAW-1:0]           m_tdata,
  output logic [USERW-1:0]           m_tuser,
  output logic [DESTW-1:0]           m_tdest,
  output logic                       m_tlast,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy
);

  localparam int PW = DATAW + USERW + DESTW + 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] sel;
  logic [1:0]     count;
  logic [PW-1:0]  head_q;
  logic [PW-1:0]  tail_q;
  logic [PW-1:0]  in_beat;
  logic           push;
  logic           pop;
  int             idx;

  // Round-robin search: lowest offset from last_grant+1 wins, so iterate downward.
  always_comb begin
    sel = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(last_grant) + 1 + k) % NUM_REQ;
      if (s_tvalid[idx]) sel = IDW'(idx);
    end
  end

  assign in_beat = {s_tdata[int'(grant_id)*DATAW +: DATAW],
                    s_tuser[int'(grant_id)*USERW +: USERW],
                    s_tdest[int'(grant_id)*DESTW +: DESTW],
                    s_tlast[grant_id]};

  // Ready depends only on registered occupancy, keeping m_tready off the s_tready path.
  always_comb begin
    s_tready = '0;
    if (state == ST_LOCK && count != 2'd2) s_tready[grant_id] = 1'b1;
  end

  assign push     = (state == ST_LOCK) && s_tvalid[grant_id] && (count != 2'd2);
  assign m_tvalid = (count != 2'd0);
  assign pop      = m_tvalid && m_tready;
  assign busy     = (state == ST_LOCK);
  assign {m_tdata, m_tuser, m_tdest, m_tlast} = head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      grant_id   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|s_tvalid) begin
            grant_id <= sel;
            state    <= ST_LOCK;
          end
        end
        default: begin
          if (push && s_tlast[grant_id]) begin
            last_grant <= grant_id;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head_q <= in_beat;
          else               tail_q <= in_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          count  <= count - 2'd1;
        end
        // push with pop only happens at occupancy 1, so the new beat becomes the head
        2'b11: head_q <= in_beat;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_inject_arbiter.sv
// tb/tb_axis_inject_arbiter.sv - scoreboard testbench for axis_inject_arbiter
module tb_axis_inject_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int UW = 8;
  localparam int TW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [TW-1:0] dest;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    s_tvalid = '0;
  logic [NR-1:0]    s_tready;
  logic [NR*DW-1:0] s_tdata = '0;
  logic [NR*UW-1:0] s_tuser = '0;
  logic [NR*TW-1:0] s_tdest = '0;
  logic [NR-1:0]    s_tlast = '0;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic [DW-1:0]    m_tdata;
  logic [UW-1:0]    m_tuser;
  logic [TW-1:0]    m_tdest;
  logic             m_tlast;
  logic [1:0]       grant_id;
  logic             busy;

  axis_inject_arbiter #(.NUM_REQ(NR), .DATAW(DW), .USERW(UW), .DESTW(TW)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tuser(s_tuser), .s_tdest(s_tdest), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tuser(m_tuser), .m_tdest(m_tdest), .m_tlast(m_tlast),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t src_q[NR][$];
  beat_t exp_q[$];
  logic  hold[NR];
  int    accepted[NR];
  int    served[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [DW-1:0] d, input logic [UW-1:0] u,
                               input logic [TW-1:0] t, input logic l);
    beat_t b;
    b.data = d; b.user = u; b.dest = t; b.last = l;
    return b;
  endfunction

  task automatic send(input int r, input beat_t b);
    src_q[r].push_back(b);
    exp_q.push_back(b);
  endtask

  // Source driver: pops a beat after each handshake and presents the next one.
  initial begin
    logic [NR-1:0] hs;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          accepted[i]++;
        end
        if (src_q[i].size() > 0 && !hold[i]) begin
          s_tvalid[i] = 1'b1;
          s_tdata[i*DW +: DW] = src_q[i][0].data;
          s_tuser[i*UW +: UW] = src_q[i][0].user;
          s_tdest[i*TW +: TW] = src_q[i][0].dest;
          s_tlast[i]          = src_q[i][0].last;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pops on each output handshake; checks stability under stall.
  initial begin
    logic  stall_prev;
    beat_t snap;
    beat_t e;
    stall_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("stall_stable", 64'({m_tdata, m_tuser, m_tdest, m_tlast}), 64'(snap));
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 64'({m_tdata, m_tuser, m_tdest, m_tlast}), 64'(e));
            served[m_tdest]++;
          end
        end
        stall_prev = m_tvalid && !m_tready;
        snap = {m_tdata, m_tuser, m_tdest, m_tlast};
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      hold[i] = 1'b0;
      accepted[i] = 0;
    end
    for (int i = 0; i < 16; i++) served[i] = 0;
    exp_q.delete();
    s_tvalid = '0;
    s_tlast = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic wait_acc(input int r, input int n, input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clk);
      #2;
      if (accepted[r] >= n) ok = 1'b1;
    end
    if (!ok) chk(nm, 64'(accepted[r]), 64'(n));
  endtask

  task automatic drain(input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) ok = 1'b1;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      hold[i] = 1'b0;
      accepted[i] = 0;
    end
    for (int i = 0; i < 16; i++) served[i] = 0;

    // Reset state
    do_reset();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_payload", 64'({m_tdata, m_tuser, m_tdest, m_tlast}), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);

    // Single 3-beat packet from req0
    release_rst();
    send(0, mk(32'hA1, 8'h11, 4'd5, 1'b0));
    send(0, mk(32'hA2, 8'h11, 4'd5, 1'b0));
    send(0, mk(32'hA3, 8'h11, 4'd5, 1'b1));
    wait_acc(0, 1, "t1_acc1_timeout");
    chk("t1_busy_mid", 64'(busy), 64'd1);
    wait_acc(0, 3, "t1_acc3_timeout");
    chk("t1_busy_after_last", 64'(busy), 64'd0);
    drain("t1_drain");

    // Simultaneous request from req0 and req1
    do_reset();
    send(0, mk(32'h0000_0B00, 8'h20, 4'd1, 1'b0));
    send(0, mk(32'h0000_0B01, 8'h20, 4'd1, 1'b1));
    send(1, mk(32'h0000_0C00, 8'h21, 4'd2, 1'b0));
    send(1, mk(32'h0000_0C01, 8'h21, 4'd2, 1'b1));
    release_rst();
    wait_acc(0, 2, "t2_acc0_timeout");
    chk("t2_gid_first", 64'(grant_id), 64'd0);
    chk("t2_idle_gap_busy", 64'(busy), 64'd0);
    chk("t2_req1_not_yet", 64'(accepted[1]), 64'd0);
    @(posedge clk);
    #2;
    chk("t2_gid_second", 64'(grant_id), 64'd1);
    chk("t2_busy_second", 64'(busy), 64'd1);
    drain("t2_drain");

    // Fairness: 4 requesters with 1-beat packets, 5 rounds
    do_reset();
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < NR; i++)
        send(i, mk(32'hF000_0000 | 32'(r * 16 + i), 8'(8'h40 + i), 4'(i), 1'b1));
    release_rst();
    drain("t3_drain");
    for (int i = 0; i < NR; i++) chk("t3_served", 64'(served[i]), 64'd5);

    // Backpressure on req2
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < 6; k++) send(2, mk(32'h10 + 32'(k), 8'h33, 4'd7, k == 5));
    release_rst();
    repeat (8) @(posedge clk);
    #2;
    chk("t4_accepted_stalled", 64'(accepted[2]), 64'd2);
    chk("t4_s_tready_low", 64'(s_tready[2]), 64'd0);
    chk("t4_m_tvalid", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    drain("t4_drain");

    // Mid-packet stall on req1 while req3 waits
    do_reset();
    send(1, mk(32'h0000_D100, 8'h51, 4'd3, 1'b0));
    send(1, mk(32'h0000_D101, 8'h51, 4'd3, 1'b0));
    send(1, mk(32'h0000_D102, 8'h51, 4'd3, 1'b1));
    send(3, mk(32'h0000_E300, 8'h53, 4'd4, 1'b1));
    release_rst();
    wait_acc(1, 1, "t5_acc_timeout");
    hold[1] = 1'b1;
    s_tvalid[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t5_req3_ready_low", 64'(s_tready[3]), 64'd0);
      chk("t5_grant_held", 64'(grant_id), 64'd1);
    end
    hold[1] = 1'b0;
    drain("t5_drain");

    // Reset during beat 2 of a 4-beat packet
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) src_q[0].push_back(mk(32'h77 + 32'(k), 8'h66, 4'd9, k == 3));
    release_rst();
    wait_acc(0, 1, "t6_acc_timeout");
    rst = 1'b1;
    #1;
    chk("t6_m_tvalid_async", 64'(m_tvalid), 64'd0);
    chk("t6_busy_async", 64'(busy), 64'd0);
    chk("t6_s_tready_async", 64'(s_tready), 64'd0);
    do_reset();
    m_tready = 1'b1;
    send(0, mk(32'h0000_9900, 8'h71, 4'd6, 1'b0));
    send(0, mk(32'h0000_9901, 8'h71, 4'd6, 1'b1));
    send(2, mk(32'h0000_9A00, 8'h72, 4'd8, 1'b1));
    release_rst();
    wait_acc(0, 1, "t6_new_acc_timeout");
    chk("t6_gid_after_rst", 64'(grant_id), 64'd0);
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
